// File: rtl/debug_pkg.sv
// Shared types for the debug controller: command opcodes, response codes and FSM states.
package debug_pkg;

  typedef enum logic [3:0] {
    CmdNop   = 4'd0,
    CmdRun   = 4'd1,
    CmdStepI = 4'd2,
    CmdStepC = 4'd3,
    CmdHalt  = 4'd4,
    CmdSetBp = 4'd5,
    CmdClrBp = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    StatOk      = 2'd0,
    StatBreak   = 2'd1,
    StatTimeout = 2'd2,
    StatAbort   = 2'd3
  } stat_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StStepI = 2'd2,
    StStepC = 2'd3
  } state_e;

  localparam int unsigned CntW = 32;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + CntW'(1);
  endfunction

  // A zero step count behaves like a single step.
  function automatic logic [CntW-1:0] step_load(input logic [CntW-1:0] arg);
    return (arg == '0) ? CntW'(1) : arg;
  endfunction

endpackage

// File: rtl/bp_match.sv
// PC breakpoint register file with set/clear port and a combinational retire-PC comparator.
module bp_match #(
  parameter int unsigned NUM_BP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_en,
  input  logic        clr_en,
  input  logic [3:0]  idx,
  input  logic [31:0] addr,
  input  logic        retired,
  input  logic [31:0] retired_pc,
  output logic        hit
);

  localparam int unsigned IdxBits = $clog2(NUM_BP);
  localparam logic [3:0]  IdxMask = 4'((1 << IdxBits) - 1);

  logic [3:0]              idx_m;
  logic                    idx_ok;
  logic [NUM_BP-1:0]       en_q, en_d;
  logic [NUM_BP-1:0][31:0] addr_q, addr_d;
  logic [NUM_BP-1:0]       match;

  // Upper index bits are ignored; a masked index can still exceed NUM_BP-1.
  assign idx_m  = idx & IdxMask;
  assign idx_ok = 32'(idx_m) < NUM_BP;

  always_comb begin
    en_d   = en_q;
    addr_d = addr_q;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (idx_ok && (32'(idx_m) == i)) begin
        if (set_en) begin
          en_d[i]   = 1'b1;
          addr_d[i] = addr;
        end else if (clr_en) begin
          en_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= '0;
      addr_q <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      match[i] = en_q[i] && (addr_q[i] == retired_pc);
    end
  end

  assign hit = retired && (|match);

endmodule

// File: rtl/debug_ctrl.sv
// Debug controller: byte-writable instruction ROM, PC breakpoints and a run/step/halt command FSM
// that reports a stop reason and active cycle count on every command.
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned ROM_BYTES   = 32,
  parameter int unsigned NUM_BP      = 4,
  parameter int unsigned MAX_RUN_CYC = 2 ** 20,
  parameter int unsigned ROM_AW      = $clog2(ROM_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [31:0]       cmd_arg,
  input  logic [3:0]        cmd_idx,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [31:0]       cycle_count,
  input  logic              rom_wr_en,
  input  logic [ROM_AW-1:0] rom_wr_addr,
  input  logic [7:0]        rom_wr_data,
  output logic              cpu_halt,
  input  logic [31:0]       imem_addr,
  output logic [31:0]       imem_data,
  input  logic              retired,
  input  logic [31:0]       retired_pc
);

  localparam logic [31:0] TimeoutAt = 32'(MAX_RUN_CYC - 1);

  state_e                      state_q, state_d;
  logic [31:0]                 cnt_q, cnt_d;
  logic [31:0]                 act_cnt_q, act_cnt_d;
  logic                        cpu_halt_q, cpu_halt_d;
  logic                        rsp_valid_q, rsp_valid_d;
  stat_e                       rsp_status_q, rsp_status_d;
  logic [31:0]                 cycle_count_q, cycle_count_d;
  logic [ROM_BYTES-1:0][7:0]   rom_q, rom_d;

  logic                        cmd_fire;
  logic                        bp_set, bp_clr, bp_hit;
  logic                        ev_break, ev_step, ev_timeout, ev_abort, step_tick;
  logic [ROM_AW-1:0]           a0, a1, a2, a3;
  logic                        unused_imem_addr;

  bp_match #(
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .clk        (clk),
    .reset      (reset),
    .set_en     (bp_set),
    .clr_en     (bp_clr),
    .idx        (cmd_idx),
    .addr       (cmd_arg),
    .retired    (retired),
    .retired_pc (retired_pc),
    .hit        (bp_hit)
  );

  // HALT is always accepted so an active command can be aborted.
  assign cmd_ready = (state_q == StIdle) || (cmd_op == CmdHalt);
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    act_cnt_d     = act_cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_status_d  = rsp_status_q;
    cycle_count_d = cycle_count_q;
    bp_set        = 1'b0;
    bp_clr        = 1'b0;
    ev_break      = 1'b0;
    ev_step       = 1'b0;
    ev_timeout    = 1'b0;
    ev_abort      = 1'b0;
    step_tick     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          case (cmd_e'(cmd_op))
            CmdRun: begin
              state_d   = StRun;
              act_cnt_d = '0;
            end
            CmdStepI: begin
              state_d   = StStepI;
              cnt_d     = step_load(cmd_arg);
              act_cnt_d = '0;
            end
            CmdStepC: begin
              state_d   = StStepC;
              cnt_d     = step_load(cmd_arg);
              act_cnt_d = '0;
            end
            default: begin
              bp_set        = (cmd_op == CmdSetBp);
              bp_clr        = (cmd_op == CmdClrBp);
              rsp_valid_d   = 1'b1;
              rsp_status_d  = StatOk;
              cycle_count_d = '0;
            end
          endcase
        end
      end
      default: begin
        act_cnt_d  = sat_inc(act_cnt_q);
        step_tick  = (state_q == StStepC) || ((state_q == StStepI) && retired);
        if (step_tick) begin
          cnt_d = cnt_q - 32'd1;
        end
        ev_break   = bp_hit && (state_q != StStepC);
        ev_step    = step_tick && (cnt_q == 32'd1);
        ev_timeout = (state_q != StStepC) && (act_cnt_q == TimeoutAt);
        ev_abort   = cmd_fire;
        if (ev_break || ev_step || ev_timeout || ev_abort) begin
          state_d       = StIdle;
          rsp_valid_d   = 1'b1;
          cycle_count_d = act_cnt_d;
          if (ev_break) begin
            rsp_status_d = StatBreak;
          end else if (ev_step) begin
            rsp_status_d = StatOk;
          end else if (ev_timeout) begin
            rsp_status_d = StatTimeout;
          end else begin
            rsp_status_d = StatAbort;
          end
        end
      end
    endcase
    cpu_halt_d = (state_d == StIdle);
  end

  // Fetch lanes wrap within the ROM; writes land only while the CPU is stalled.
  assign a0 = imem_addr[ROM_AW-1:0];
  assign a1 = a0 + ROM_AW'(1);
  assign a2 = a0 + ROM_AW'(2);
  assign a3 = a0 + ROM_AW'(3);
  assign imem_data = {rom_q[a3], rom_q[a2], rom_q[a1], rom_q[a0]};
  assign unused_imem_addr = ^imem_addr[31:ROM_AW];

  always_comb begin
    rom_d = rom_q;
    if (rom_wr_en && cpu_halt_q) begin
      rom_d[rom_wr_addr] = rom_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      act_cnt_q     <= '0;
      cpu_halt_q    <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= StatOk;
      cycle_count_q <= '0;
      rom_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      act_cnt_q     <= act_cnt_d;
      cpu_halt_q    <= cpu_halt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      cycle_count_q <= cycle_count_d;
      rom_q         <= rom_d;
    end
  end

  assign cpu_halt    = cpu_halt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_status  = rsp_status_q;
  assign cycle_count = cycle_count_q;

endmodule
